serial_twos_decoder: RTL and testbench

Receive-side companion to the bit-serial two's-complement inverter. Accepts an LSB-first serial two's-complement stream, undoes the complement bit-serially (pass bits up to and including the first 1, invert after), and reassembles a parallel word. Presents the word on a valid/ready output with framing-error and overrun reporting. Sits between the serial link and the parallel datapath consumer.

---
 rtl/serial_twos_pkg.sv | 13 +
 rtl/twos_bit_cell.sv | 39 +++
 rtl/serial_twos_decoder.sv | 162 ++++++++++++++++
 tb/tb_serial_twos_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_twos_pkg.sv
// Shared definitions for the serial two's-complement decoder.
//   DefaultWidth : default bits per serial word
//   state_e      : framing FSM states (hunt for bit 0, receive rest of word)
package serial_twos_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [0:0] {
    StHunt,
    StRecv
  } state_e;

endpackage

// File: rtl/twos_bit_cell.sv
// Bit-serial two's-complement undo cell.
// Bits pass unchanged up to and including the first 1 of a word.
// Every bit after that first 1 is inverted.
//   t_clk : clock, rising edge
//   r     : asynchronous active-high reset
//   b     : incoming serial bit
//   en    : b is accepted this cycle
//   first : b is bit 0 of a word (restarts the seen-one tracking)
//   d     : decoded bit, combinational from b and the stored flag
module twos_bit_cell (
  input  logic t_clk,
  input  logic r,
  input  logic b,
  input  logic en,
  input  logic first,
  output logic d
);

  logic seen_one_q, seen_one_d;

  always_comb begin
    seen_one_d = seen_one_q;
    if (en) begin
      seen_one_d = first ? b : (seen_one_q | b);
    end
  end

  // Bit 0 always passes through, so a stale flag from the previous word is ignored.
  assign d = (seen_one_q && !first) ? ~b : b;

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

endmodule

// File: rtl/serial_twos_decoder.sv
// Receive-side serial two's-complement decoder.
// Frames an LSB-first serial stream, undoes the complement bit-serially and
// presents the reassembled word on a valid/ready interface.
//   t_clk, r           : clock, async active-high reset
//   s_bit/s_valid/s_first : serial input; s_first marks bit 0
//   m_data / m_raw     : decoded word / word as received
//   m_neg_max          : raw word is 1 followed by WIDTH-1 zeros
//   m_valid / m_ready  : output handshake
//   frm_err            : one-cycle pulse on a framing error
//   overrun / ovr_clr  : sticky dropped-word flag and its synchronous clear
module serial_twos_decoder
  import serial_twos_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_first,
  output logic [WIDTH-1:0] m_data,
  output logic [WIDTH-1:0] m_raw,
  output logic             m_neg_max,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frm_err,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] NegMax  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] dec_q, dec_d;
  logic [WIDTH-1:0] m_data_d, m_raw_d;
  logic             m_neg_max_d, m_valid_d, frm_err_d, overrun_d;

  logic accept;
  logic bit0;
  logic last;
  logic load;
  logic drop;
  logic dec_bit;

  twos_bit_cell u_cell (
    .t_clk (t_clk),
    .r     (r),
    .b     (s_bit),
    .en    (accept),
    .first (bit0),
    .d     (dec_bit)
  );

  // Framing FSM and bit counter.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    accept    = 1'b0;
    bit0      = 1'b0;
    frm_err_d = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (s_valid) begin
          if (s_first) begin
            accept = 1'b1;
            bit0   = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end
      end
      StRecv: begin
        if (s_valid) begin
          // A premature s_first abandons the partial word and restarts on this bit.
          accept    = 1'b1;
          bit0      = s_first;
          frm_err_d = s_first;
        end
      end
      default: ;
    endcase

    last = accept && !bit0 && (count_q == LastCnt);

    if (accept) begin
      if (last) begin
        state_d = StHunt;
        count_d = '0;
      end else begin
        state_d = StRecv;
        count_d = bit0 ? CNT_W'(1) : count_q + CNT_W'(1);
      end
    end
  end

  // Shift registers and output/handshake logic.
  always_comb begin
    raw_d       = raw_q;
    dec_d       = dec_q;
    m_data_d    = m_data;
    m_raw_d     = m_raw;
    m_neg_max_d = m_neg_max;
    m_valid_d   = m_valid;
    overrun_d   = overrun;

    if (accept) begin
      raw_d = {s_bit, raw_q[WIDTH-1:1]};
      dec_d = {dec_bit, dec_q[WIDTH-1:1]};
    end

    load = last && (!m_valid || m_ready);
    drop = last && m_valid && !m_ready;

    if (m_valid && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (load) begin
      m_data_d    = dec_d;
      m_raw_d     = raw_d;
      m_neg_max_d = (raw_d == NegMax);
      m_valid_d   = 1'b1;
    end

    // Set has priority over clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q   <= StHunt;
      count_q   <= '0;
      raw_q     <= '0;
      dec_q     <= '0;
      m_data    <= '0;
      m_raw     <= '0;
      m_neg_max <= 1'b0;
      m_valid   <= 1'b0;
      frm_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      raw_q     <= raw_d;
      dec_q     <= dec_d;
      m_data    <= m_data_d;
      m_raw     <= m_raw_d;
      m_neg_max <= m_neg_max_d;
      m_valid   <= m_valid_d;
      frm_err   <= frm_err_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_serial_twos_decoder.sv
// Scoreboard bench for serial_twos_decoder (WIDTH = 8).
// Stimulus pushes hand-computed expected words; a negedge monitor pops and
// compares on every accepted output handshake.
module tb_serial_twos_decoder;

  logic       t_clk = 1'b0;
  logic       r;
  logic       s_bit, s_valid, s_first;
  logic [7:0] m_data, m_raw;
  logic       m_neg_max, m_valid, m_ready;
  logic       frm_err, overrun, ovr_clr;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] raw;
    logic       neg;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  serial_twos_decoder #(.WIDTH(8)) dut (
    .t_clk     (t_clk),
    .r         (r),
    .s_bit     (s_bit),
    .s_valid   (s_valid),
    .s_first   (s_first),
    .m_data    (m_data),
    .m_raw     (m_raw),
    .m_neg_max (m_neg_max),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frm_err   (frm_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 t_clk = ~t_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [7:0] rw, input logic n);
    exp_t e;
    e.data = d;
    e.raw  = rw;
    e.neg  = n;
    exp_q.push_back(e);
  endtask

  // Drives one bit for exactly one rising edge; returns at edge + 1.
  task automatic send_bit(input logic b, input logic f);
    s_bit   = b;
    s_valid = 1'b1;
    s_first = f;
    @(posedge t_clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_first = 1'b0;
    @(posedge t_clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], i == 0);
      if (gaps && (i % 3 == 1)) idle();
    end
  endtask

  // Scoreboard monitor.
  always @(negedge t_clk) begin
    if (!r && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_word: got data 0x%0h raw 0x%0h, required no output at %0t",
                 m_data, m_raw, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e.data));
        check("m_raw", 32'(m_raw), 32'(e.raw));
        check("m_neg_max", 32'(m_neg_max), 32'(e.neg));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    r = 1'b1; s_bit = 1'b0; s_valid = 1'b0; s_first = 1'b0;
    m_ready = 1'b1; ovr_clr = 1'b0;
    #2;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_raw", 32'(m_raw), 0);
    check("rst_m_neg_max", 32'(m_neg_max), 0);
    check("rst_frm_err", 32'(frm_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    #20;
    r = 1'b0;
    @(posedge t_clk);
    #1;

    // Basic decode and one-cycle latency.
    push_exp(8'h05, 8'hFB, 1'b0);
    send_word(8'hFB, 1'b0);
    check("latency_valid", 32'(m_valid), 1);
    idle();

    // Back-to-back words: most negative, zero, and two more.
    push_exp(8'h80, 8'h80, 1'b1);
    send_word(8'h80, 1'b0);
    push_exp(8'h00, 8'h00, 1'b0);
    send_word(8'h00, 1'b0);
    push_exp(8'h02, 8'hFE, 1'b0);
    send_word(8'hFE, 1'b0);
    push_exp(8'h01, 8'hFF, 1'b0);
    send_word(8'hFF, 1'b0);
    idle();
    idle();

    // Backpressure and overrun.
    m_ready = 1'b0;
    push_exp(8'h05, 8'hFB, 1'b0);
    send_word(8'hFB, 1'b0);
    send_word(8'hFE, 1'b0);
    idle();
    check("ovr_set", 32'(overrun), 1);
    check("ovr_hold_data", 32'(m_data), 32'h05);
    check("ovr_hold_raw", 32'(m_raw), 32'hFB);
    check("ovr_hold_valid", 32'(m_valid), 1);
    m_ready = 1'b1;
    idle();
    check("valid_drop", 32'(m_valid), 0);
    check("ovr_sticky", 32'(overrun), 1);
    ovr_clr = 1'b1;
    idle();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 0);

    // Premature s_first at bit 4 restarts a 0xFF word.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("no_frm_mid", 32'(frm_err), 0);
    push_exp(8'h01, 8'hFF, 1'b0);
    send_bit(1'b1, 1'b1);
    check("frm_restart_pulse", 32'(frm_err), 1);
    send_bit(1'b1, 1'b0);
    check("frm_restart_end", 32'(frm_err), 0);
    for (int i = 2; i < 8; i++) send_bit(1'b1, 1'b0);
    idle();

    // Unframed bit in HUNT, then a gapped word.
    send_bit(1'b1, 1'b0);
    check("frm_hunt_pulse", 32'(frm_err), 1);
    idle();
    check("frm_hunt_end", 32'(frm_err), 0);
    push_exp(8'h05, 8'hFB, 1'b0);
    send_word(8'hFB, 1'b1);
    idle();
    push_exp(8'h80, 8'h80, 1'b1);
    send_word(8'h80, 1'b1);
    idle();

    // Async reset while holding a word with overrun set, mid-word.
    m_ready = 1'b0;
    send_word(8'hFB, 1'b0);
    send_word(8'hFE, 1'b0);
    check("pre_rst_valid", 32'(m_valid), 1);
    check("pre_rst_ovr", 32'(overrun), 1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    #2;
    r = 1'b1;
    #1;
    check("arst_valid", 32'(m_valid), 0);
    check("arst_data", 32'(m_data), 0);
    check("arst_raw", 32'(m_raw), 0);
    check("arst_ovr", 32'(overrun), 0);
    check("arst_neg", 32'(m_neg_max), 0);
    #12;
    r = 1'b0;
    m_ready = 1'b1;
    @(posedge t_clk);
    #1;
    push_exp(8'h05, 8'hFB, 1'b0);
    send_word(8'hFB, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expected words never presented, required 0", exp_q.size());
    end
    idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
